divider_pipelined_param: RTL
============================

// Module: divider_pipelined_param
//
// PURPOSE
//  Parametrised, fully pipelined restoring divider for the multicycle/pipelined datapath.
//  Accepts one DIV/DIVU/REM/REMU op per cycle, carries a tag alongside it, and returns
//  quotient, remainder and op-selected result STAGES cycles later.
//  Global stall freezes the whole pipe. Replaces the fixed 32-bit two-half divider.
//
// PARAMETERS
//  WIDTH   32  operand/result width in bits
//  STAGES  8   pipeline register stages; each stage performs WIDTH/STAGES iterations
//  TAG_W   5   width of opaque tag carried with each op (e.g. destination register)
//
// PORTS
//  clk          in   1        clock
//  rst          in   1        reset
//  i_valid      in   1        op present on inputs this cycle
//  i_op         in   2        00 DIV, 01 DIVU, 10 REM, 11 REMU (= funct3[1:0])
//  i_tag        in   TAG_W    tag, returned unchanged with result
//  i_dividend   in   WIDTH    dividend
//  i_divisor    in   WIDTH    divisor
//  i_stall      in   1        1 = hold every stage register, accept no input
//  o_valid      out  1        result valid
//  o_tag        out  TAG_W    tag of the result
//  o_quotient   out  WIDTH    quotient
//  o_remainder  out  WIDTH    remainder
//  o_result     out  WIDTH    quotient if op[1]==0, else remainder
//
// BEHAVIOUR
//  - Reset: rst, synchronous, active-high; clock clk (posedge).
//    Reset clears all stage valid bits and outputs:
//    o_valid=0, o_tag=0, o_quotient=0, o_remainder=0, o_result=0.
//    Ops in flight when rst asserts are discarded, never emitted.
//  - Elaboration: WIDTH%STAGES!=0 or STAGES<1 or STAGES>WIDTH -> $error.
//  - Latency: op sampled at edge t (i_valid=1, i_stall=0) -> o_valid=1 after edge
//    t+STAGES-1 (visible STAGES cycles later). Throughput 1 op/cycle.
//    Final stage is registered; outputs are flop outputs.
//  - Stall: i_stall=1 -> no register in the pipe changes (including valid bits and outputs);
//    inputs are ignored that cycle. o_valid held at current value.
//    rst has priority over i_stall.
//  - Bubbles: i_valid=0 inserts a bubble. Data regs of invalid stages may hold don't-care;
//    outputs change only when a valid op exits (o_* hold last valid result otherwise).
//  - Unsigned core per iteration: r=(r<<1)|msb(a); a<<=1; if r>=d {r-=d; q=(q<<1)|1}
//    else q<<=1. Internal r is WIDTH+1 bits so compare is exact when d has MSB set.
//  - Signed ops (DIV/REM): core operates on |a|,|d| (unsigned, so |-2^(W-1)|=2^(W-1)).
//    Negate q iff sign(a)!=sign(d) AND d!=0. Negate r iff a<0.
//    Sign flags and d==0 flag travel with the op through all stages.
//  - Boundary results (RISC-V):
//    - d==0 (any op): q=all ones, r=a.
//    - DIV/REM with a=-2^(W-1), d=-1: q=a, r=0.
//
// CONFIGURATION
//  DIVIDER_SIGNED_EN defined: behaviour as above.
//  Undefined: i_op[0] ignored; DIV/REM execute as DIVU/REMU.
//    No abs/negate logic and no sign flags are instantiated.
//
// TESTING (WIDTH=32, STAGES=8, DIVIDER_SIGNED_EN defined unless noted)
//  1. DIVU 100/7, tag 3 -> o_valid exactly 8 cycles later, q=14, r=2, tag=3,
//     o_result=14.
//  2. Back-to-back 8 ops (i_valid every cycle), i_stall=1 for 3 cycles mid-stream
//     -> 8 results, in order, correct tags, o_valid stretched not duplicated.
//  3. DIV -7/2 -> q=-3 (0xFFFFFFFD); REM -7/2 -> r=-1; REM 7/-2 -> r=1.
//  4. DIVU 0x1234/0 -> q=0xFFFFFFFF, r=0x1234; DIV -5/0 -> q=0xFFFFFFFF, r=-5;
//     DIV 0x80000000/-1 -> q=0x80000000, r=0.
//  5. DIVU 0xFFFFFFFF/0x80000001 -> q=1, r=0x7FFFFFFE;
//     rst asserted with 4 ops in flight -> no o_valid afterwards, outputs 0.
//  6. Macro undefined: DIV 0xFFFFFFF9/2 -> q=0x7FFFFFFC, r=1 (unsigned);
//     random DIVU vs model, STAGES in {1,4,32}.

Source files
------------

// File: rtl/divider_pipelined_param.sv
// Fully pipelined restoring divider: one DIV/DIVU/REM/REMU per cycle, result STAGES cycles later.
// Signed ops need DIVIDER_SIGNED_EN; without it every op runs unsigned.
module divider_pipelined_param #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 8,
   parameter int TAG_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic [1:0]       i_op,
   input  logic [TAG_W-1:0] i_tag,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   input  logic             i_stall,
   output logic             o_valid,
   output logic [TAG_W-1:0] o_tag,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic [WIDTH-1:0] o_result
);

   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("divider_pipelined_param: need 1 <= STAGES <= WIDTH and WIDTH a multiple of STAGES");
   end

   localparam int ITER = WIDTH / ((STAGES < 1) ? 1 : STAGES);

   // aq starts as the dividend and fills with quotient bits as they are shifted out.
   // In the last stage the fields are reused: aq=quotient, rem=remainder, div=selected result.
   typedef struct packed {
      logic             valid;
      logic             sel_rem;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] rem;
      logic [WIDTH-1:0] aq;
      logic [WIDTH-1:0] div;
`ifdef DIVIDER_SIGNED_EN
      logic             neg_q;
      logic             neg_r;
`endif
   } stage_t;

   function automatic stage_t run_iters(stage_t s);
      stage_t         t;
      logic [WIDTH:0] trial;
      t = s;
      for (int i = 0; i < ITER; i++) begin
         // one extra bit keeps the compare exact when the divisor MSB is set
         trial = {t.rem, t.aq[WIDTH-1]};
         t.aq  = t.aq << 1;
         if (trial >= {1'b0, t.div}) begin
            trial   = trial - {1'b0, t.div};
            t.aq[0] = 1'b1;
         end
         t.rem = trial[WIDTH-1:0];
      end
      return t;
   endfunction

   function automatic stage_t finish(stage_t s);
      stage_t t;
      t = s;
`ifdef DIVIDER_SIGNED_EN
      if (s.neg_q) t.aq  = -s.aq;
      if (s.neg_r) t.rem = -s.rem;
`endif
      t.div = t.sel_rem ? t.rem : t.aq;
      return t;
   endfunction

   stage_t entry;
   stage_t res    [STAGES];
   stage_t pipe_q [STAGES];

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      entry         = '0;
      entry.valid   = i_valid;
      entry.sel_rem = i_op[1];
      entry.tag     = i_tag;
      entry.aq      = i_dividend;
      entry.div     = i_divisor;
`ifdef DIVIDER_SIGNED_EN
      if (!i_op[0]) begin
         if (i_dividend[WIDTH-1]) entry.aq  = -i_dividend;
         if (i_divisor[WIDTH-1])  entry.div = -i_divisor;
         entry.neg_q = (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]) && (i_divisor != '0);
         entry.neg_r = i_dividend[WIDTH-1];
      end
`endif
   end

`ifndef DIVIDER_SIGNED_EN
   logic unused_op0;
   assign unused_op0 = i_op[0];
`endif

   always_comb begin
      res[0] = run_iters(entry);
      for (int k = 1; k < STAGES; k++) begin
         res[k] = run_iters(pipe_q[k-1]);
      end
   end

   // NOTE: registers are assigned with <= so every stage samples the previous stage's old value.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: only valid bits and the output stage are cleared; mid-stage data is don't-care.
         for (int k = 0; k < STAGES; k++) begin
            pipe_q[k].valid <= 1'b0;
         end
         pipe_q[STAGES-1] <= '0;
      end else if (!i_stall) begin
         for (int k = 0; k < STAGES - 1; k++) begin
            pipe_q[k] <= res[k];
         end
         pipe_q[STAGES-1].valid <= res[STAGES-1].valid;
         if (res[STAGES-1].valid) begin
            pipe_q[STAGES-1] <= finish(res[STAGES-1]);
         end
      end
   end

   assign o_valid     = pipe_q[STAGES-1].valid;
   assign o_tag       = pipe_q[STAGES-1].tag;
   assign o_quotient  = pipe_q[STAGES-1].aq;
   assign o_remainder = pipe_q[STAGES-1].rem;
   assign o_result    = pipe_q[STAGES-1].div;

endmodule
